// File: rtl/ubksa_sum_accumulator.sv
// Frame accumulator for the UBKSA adder's unsigned sum: adds CNT samples, then holds the total on a valid/ready port.
// Optional build macro UBKSA_ACC_SAT_EN selects saturating accumulation with a per-frame overflow flag.
module ubksa_sum_accumulator #(
    parameter int IN_W  = 11,
    parameter int CNT   = 16,
    parameter int ACC_W = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [IN_W-1:0]  I_S,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [ACC_W-1:0] O_SUM,
    output logic             O_OVF
);

    localparam int              CNT_W    = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [ACC_W-1:0] acc_r, acc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [ACC_W-1:0] sum_r, sum_s;
    logic             valid_r, valid_s;
    logic             ready_r, ready_s;
    logic [ACC_W-1:0] frame_s;
    logic             carry_s;

`ifdef UBKSA_ACC_SAT_EN
    logic [ACC_W:0]   wide_s;
    logic             flag_r, flag_s;
    logic             ovf_r, ovf_s;

    // Clamp to all-ones whenever the add carries out of the accumulator width.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W:0] wide);
        if (wide[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return wide[ACC_W-1:0];
        end
    endfunction

    // Saturating add of the zero-extended sample into the running total.
    always_comb begin
        wide_s  = {1'b0, acc_r} + (ACC_W + 1)'(I_S);
        frame_s = sat_add(wide_s);
        carry_s = wide_s[ACC_W];
    end
`else
    // Modular add of the zero-extended sample into the running total.
    always_comb begin
        frame_s = acc_r + ACC_W'(I_S);
        carry_s = 1'b0;
    end
`endif

    // Next-state, datapath and handshake decode; HOLD blocks input until the result is taken.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        valid_s = valid_r;
`ifdef UBKSA_ACC_SAT_EN
        flag_s  = flag_r;
        ovf_s   = ovf_r;
`endif
        case (state_r)
            ST_ACC: begin
                if (I_VALID) begin
                    if (cnt_r == CNT_LAST) begin
                        sum_s   = frame_s;
                        valid_s = 1'b1;
                        acc_s   = {ACC_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_HOLD;
`ifdef UBKSA_ACC_SAT_EN
                        ovf_s   = flag_r | carry_s;
                        flag_s  = 1'b0;
`endif
                    end else begin
                        acc_s   = frame_s;
                        cnt_s   = cnt_r + CNT_W'(1);
`ifdef UBKSA_ACC_SAT_EN
                        flag_s  = flag_r | carry_s;
`endif
                    end
                end else begin
                    acc_s = acc_r;
                    cnt_s = cnt_r;
                end
            end
            ST_HOLD: begin
                if (O_READY) begin
                    valid_s = 1'b0;
                    state_s = ST_ACC;
                end else begin
                    valid_s = 1'b1;
                    state_s = ST_HOLD;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = ST_ACC;
            end
        endcase
        ready_s = (state_s == ST_ACC);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_ACC;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {ACC_W{1'b0}};
            valid_r <= 1'b0;
            ready_r <= 1'b1;
`ifdef UBKSA_ACC_SAT_EN
            flag_r  <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            valid_r <= valid_s;
            ready_r <= ready_s;
`ifdef UBKSA_ACC_SAT_EN
            flag_r  <= flag_s;
            ovf_r   <= ovf_s;
`endif
        end
    end

    assign I_READY = ready_r;
    assign O_VALID = valid_r;
    assign O_SUM   = sum_r;
`ifdef UBKSA_ACC_SAT_EN
    assign O_OVF   = ovf_r;
`else
    assign O_OVF   = 1'b0;
`endif

endmodule

// File: tb/tb_ubksa_sum_accumulator.sv
// Directed bench for ubksa_sum_accumulator: default, narrow (ACC_W=12, CNT=4) and single-sample (CNT=1) instances.
module tb_ubksa_sum_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic        a_i_valid, a_i_ready, a_o_valid, a_o_ready, a_o_ovf;
    logic [10:0] a_i_s;
    logic [14:0] a_o_sum;
    logic        b_i_valid, b_i_ready, b_o_valid, b_o_ready, b_o_ovf;
    logic [10:0] b_i_s;
    logic [11:0] b_o_sum;
    logic        c_i_valid, c_i_ready, c_o_valid, c_o_ready, c_o_ovf;
    logic [10:0] c_i_s;
    logic [14:0] c_o_sum;

`ifdef UBKSA_ACC_SAT_EN
    localparam logic [11:0] T5_SUM = 12'd4095;
    localparam logic        T5_OVF = 1'b1;
`else
    localparam logic [11:0] T5_SUM = 12'd4092;
    localparam logic        T5_OVF = 1'b0;
`endif

    ubksa_sum_accumulator dut (
        .CLK(clk), .RST(rst), .I_VALID(a_i_valid), .I_READY(a_i_ready), .I_S(a_i_s),
        .O_VALID(a_o_valid), .O_READY(a_o_ready), .O_SUM(a_o_sum), .O_OVF(a_o_ovf)
    );

    ubksa_sum_accumulator #(.IN_W(11), .CNT(4), .ACC_W(12)) dut_narrow (
        .CLK(clk), .RST(rst), .I_VALID(b_i_valid), .I_READY(b_i_ready), .I_S(b_i_s),
        .O_VALID(b_o_valid), .O_READY(b_o_ready), .O_SUM(b_o_sum), .O_OVF(b_o_ovf)
    );

    ubksa_sum_accumulator #(.IN_W(11), .CNT(1), .ACC_W(15)) dut_single (
        .CLK(clk), .RST(rst), .I_VALID(c_i_valid), .I_READY(c_i_ready), .I_S(c_i_s),
        .O_VALID(c_o_valid), .O_READY(c_o_ready), .O_SUM(c_o_sum), .O_OVF(c_o_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [10:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            a_i_valid = 1'b1;
            a_i_s     = v;
            tick();
        end
        a_i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_i_valid = 1'b0; a_i_s = 11'd0; a_o_ready = 1'b1;
        b_i_valid = 1'b0; b_i_s = 11'd0; b_o_ready = 1'b1;
        c_i_valid = 1'b0; c_i_s = 11'd0; c_o_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (a_o_valid !== 1'b0 || a_o_sum !== 15'd0 || a_o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b sum=%0d ovf=%b exp 0/0/0", a_o_valid, a_o_sum, a_o_ovf);
        end
        checks++;
        if (a_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_i_ready got=%b exp=1", a_i_ready);
        end
    endtask

    task automatic test_full_scale();
        a_o_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_i_valid = 1'b1;
            a_i_s     = 11'd2047;
            tick();
            if (i < 15) begin
                checks++;
                if (a_o_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL t1_early_valid sample=%0d got=%b exp=0", i, a_o_valid);
                end
            end
        end
        a_i_valid = 1'b0;
        checks++;
        if (a_o_valid !== 1'b1 || a_o_sum !== 15'd32752 || a_o_ovf !== 1'b0 || a_i_ready !== 1'b0) begin
            failures++;
            $display("FAIL t1_result got valid=%b sum=%0d ovf=%b rdy=%b exp 1/32752/0/0",
                     a_o_valid, a_o_sum, a_o_ovf, a_i_ready);
        end
        tick();
        checks++;
        if (a_o_valid !== 1'b0 || a_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL t1_release got valid=%b rdy=%b exp 0/1", a_o_valid, a_i_ready);
        end
    endtask

    task automatic test_gaps();
        a_o_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            if ((v % 3) == 0 || v == 7) begin
                a_i_valid = 1'b0;
                a_i_s     = 11'(v + 500);
                tick();
                checks++;
                if (a_i_ready !== 1'b1 || a_o_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL t2_gap v=%0d got rdy=%b valid=%b exp 1/0", v, a_i_ready, a_o_valid);
                end
            end
            a_i_valid = 1'b1;
            a_i_s     = 11'(v);
            tick();
        end
        a_i_valid = 1'b0;
        checks++;
        if (a_o_valid !== 1'b1 || a_o_sum !== 15'd136) begin
            failures++;
            $display("FAIL t2_result got valid=%b sum=%0d exp 1/136", a_o_valid, a_o_sum);
        end
        tick();
    endtask

    task automatic test_backpressure();
        a_o_ready = 1'b0;
        feed_a(11'd3, 16);
        for (int i = 0; i < 5; i++) begin
            a_i_valid = 1'b1;
            a_i_s     = 11'd7;
            checks++;
            if (a_o_valid !== 1'b1 || a_o_sum !== 15'd48 || a_i_ready !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold cyc=%0d got valid=%b sum=%0d rdy=%b exp 1/48/0",
                         i, a_o_valid, a_o_sum, a_i_ready);
            end
            tick();
        end
        a_i_valid = 1'b0;
        a_o_ready = 1'b1;
        tick();
        checks++;
        if (a_o_valid !== 1'b0 || a_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_release got valid=%b rdy=%b exp 0/1", a_o_valid, a_i_ready);
        end
    endtask

    task automatic test_back_to_back();
        a_o_ready = 1'b1;
        feed_a(11'd2, 16);
        checks++;
        if (a_o_valid !== 1'b1 || a_o_sum !== 15'd32) begin
            failures++;
            $display("FAIL b2b_sum got valid=%b sum=%0d exp 1/32", a_o_valid, a_o_sum);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        feed_a(11'd100, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (a_o_valid !== 1'b0 || a_o_sum !== 15'd0 || a_o_ovf !== 1'b0 || a_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL t4_after_rst got valid=%b sum=%0d ovf=%b rdy=%b exp 0/0/0/1",
                     a_o_valid, a_o_sum, a_o_ovf, a_i_ready);
        end
        feed_a(11'd1, 16);
        checks++;
        if (a_o_valid !== 1'b1 || a_o_sum !== 15'd16) begin
            failures++;
            $display("FAIL t4_sum got valid=%b sum=%0d exp 1/16", a_o_valid, a_o_sum);
        end
        tick();
        a_o_ready = 1'b0;
        feed_a(11'd5, 16);
        checks++;
        if (a_o_valid !== 1'b1 || a_o_sum !== 15'd80) begin
            failures++;
            $display("FAIL t4_hold_sum got valid=%b sum=%0d exp 1/80", a_o_valid, a_o_sum);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_o_ready = 1'b1;
        checks++;
        if (a_o_valid !== 1'b0 || a_o_sum !== 15'd0 || a_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL t4_hold_rst got valid=%b sum=%0d rdy=%b exp 0/0/1", a_o_valid, a_o_sum, a_i_ready);
        end
    endtask

    task automatic test_overflow();
        b_o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_i_valid = 1'b1;
            b_i_s     = 11'd2047;
            tick();
        end
        b_i_valid = 1'b0;
        checks++;
        if (b_o_valid !== 1'b1 || b_o_sum !== T5_SUM || b_o_ovf !== T5_OVF) begin
            failures++;
            $display("FAIL t5_ovf got valid=%b sum=%0d ovf=%b exp 1/%0d/%b",
                     b_o_valid, b_o_sum, b_o_ovf, T5_SUM, T5_OVF);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            b_i_valid = 1'b1;
            b_i_s     = 11'd1;
            tick();
        end
        b_i_valid = 1'b0;
        checks++;
        if (b_o_valid !== 1'b1 || b_o_sum !== 12'd4 || b_o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL t5_next_frame got valid=%b sum=%0d ovf=%b exp 1/4/0", b_o_valid, b_o_sum, b_o_ovf);
        end
        tick();
    endtask

    task automatic test_single_sample();
        c_o_ready = 1'b1;
        c_i_valid = 1'b1;
        c_i_s     = 11'd5;
        tick();
        c_i_s = 11'd9;
        checks++;
        if (c_o_valid !== 1'b1 || c_o_sum !== 15'd5 || c_i_ready !== 1'b0) begin
            failures++;
            $display("FAIL t6_first got valid=%b sum=%0d rdy=%b exp 1/5/0", c_o_valid, c_o_sum, c_i_ready);
        end
        tick();
        checks++;
        if (c_o_valid !== 1'b0 || c_i_ready !== 1'b1) begin
            failures++;
            $display("FAIL t6_idle got valid=%b rdy=%b exp 0/1", c_o_valid, c_i_ready);
        end
        tick();
        c_i_valid = 1'b0;
        checks++;
        if (c_o_valid !== 1'b1 || c_o_sum !== 15'd9) begin
            failures++;
            $display("FAIL t6_second got valid=%b sum=%0d exp 1/9", c_o_valid, c_o_sum);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_gaps();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_overflow();
        test_single_sample();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
